// File: rtl/dtw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dtw_pkg
// Description : Shared definitions for the DTW result path. Holds the
//               collector state encoding, the cost width shared with the PE
//               array and the saturated "no match yet" cost value.
// Revision    : 1.0 - initial release
// ============================================================================
package dtw_pkg;

  // Cost width shared with the systolic PE array.
  localparam int unsigned DTW_WIDTH = 16;

  // Saturated cost; it never wins a strict-less compare.
  localparam logic [DTW_WIDTH-1:0] COST_MAX = {DTW_WIDTH{1'b1}};

  // Collector state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dtw_state_e;

endpackage : dtw_pkg
`default_nettype wire

// File: rtl/dtw_min_tracker.sv
`default_nettype none
// ============================================================================
// Module      : dtw_min_tracker
// Description : Registered running minimum with its argmin index.
//               The compare is a strict unsigned less-than, so on ties the
//               earliest index is kept. Clear has priority over update.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               clr_i        - restart tracking (min = all ones, arg = 0)
//               upd_i        - offer val_i/idx_i as a candidate this cycle
//               val_i, idx_i - candidate value and its index
//               min_o, arg_o - current minimum and its index
//               lower_o      - val_i is strictly below min_o (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module dtw_min_tracker
  import dtw_pkg::*;
#(
  parameter int unsigned WIDTH     = DTW_WIDTH,
  parameter int unsigned IDX_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 upd_i,
  input  logic [WIDTH-1:0]     val_i,
  input  logic [IDX_WIDTH-1:0] idx_i,
  output logic [WIDTH-1:0]     min_o,
  output logic [IDX_WIDTH-1:0] arg_o,
  output logic                 lower_o
);

  localparam logic [WIDTH-1:0] c_cost_max = {WIDTH{1'b1}};

  logic [WIDTH-1:0]     min_q, min_d;
  logic [IDX_WIDTH-1:0] arg_q, arg_d;
  logic                 w_lower;

  assign w_lower = (val_i < min_q);

  always_comb begin
    min_d = min_q;
    arg_d = arg_q;
    if (clr_i) begin
      min_d = c_cost_max;
      arg_d = '0;
    end else if (upd_i && w_lower) begin
      min_d = val_i;
      arg_d = idx_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= c_cost_max;
      arg_q <= '0;
    end else begin
      min_q <= min_d;
      arg_q <= arg_d;
    end
  end

  assign min_o   = min_q;
  assign arg_o   = arg_q;
  assign lower_o = w_lower;

endmodule : dtw_min_tracker
`default_nettype wire

// File: rtl/dtw_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : dtw_result_collector
// Description : Output stage of the DTW systolic array. Enables the array for
//               one scoring run, tracks the minimum accumulated cost and the
//               reference position where it occurred, then hands score,
//               position and threshold-hit flag over a valid/ready handshake.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start               - run request (honoured in IDLE only)
//               ref_len, threshold  - run length and hit threshold, latched
//                                     on start
//               dtw_in, dtw_valid   - cost stream from the last PE
//               running, busy       - PE enable / collector occupied
//               res_valid, res_ready- result handshake
//               res_score, res_pos, res_hit - result payload
// Revision    : 1.0 - initial release
// ============================================================================
module dtw_result_collector
  import dtw_pkg::*;
#(
  parameter int unsigned WIDTH     = DTW_WIDTH,
  parameter int unsigned IDX_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IDX_WIDTH-1:0] ref_len,
  input  logic [WIDTH-1:0]     threshold,
  input  logic [WIDTH-1:0]     dtw_in,
  input  logic                 dtw_valid,
  output logic                 running,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_score,
  output logic [IDX_WIDTH-1:0] res_pos,
  output logic                 res_hit
);

  localparam logic [WIDTH-1:0]     c_cost_max = {WIDTH{1'b1}};
  localparam logic [IDX_WIDTH-1:0] c_idx_one  = IDX_WIDTH'(1);

  dtw_state_e           state_q, state_d;
  logic [IDX_WIDTH-1:0] ref_len_q, ref_len_d;
  logic [WIDTH-1:0]     thr_q, thr_d;
  logic [IDX_WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0]     res_score_q, res_score_d;
  logic [IDX_WIDTH-1:0] res_pos_q, res_pos_d;
  logic                 res_hit_q, res_hit_d;

  logic                 w_trk_clr;
  logic                 w_trk_upd;
  logic [WIDTH-1:0]     w_trk_min;
  logic [IDX_WIDTH-1:0] w_trk_arg;
  logic                 w_trk_lower;
  logic                 w_last;
  logic [WIDTH-1:0]     w_final_score;
  logic [IDX_WIDTH-1:0] w_final_pos;

  dtw_min_tracker #(
    .WIDTH     (WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_min_tracker (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (w_trk_clr),
    .upd_i   (w_trk_upd),
    .val_i   (dtw_in),
    .idx_i   (count_q),
    .min_o   (w_trk_min),
    .arg_o   (w_trk_arg),
    .lower_o (w_trk_lower)
  );

  // The tracker registers lag one sample, so the result captured on the last
  // sample folds that sample in here rather than waiting a cycle.
  assign w_final_score = w_trk_lower ? dtw_in  : w_trk_min;
  assign w_final_pos   = w_trk_lower ? count_q : w_trk_arg;

  // ref_len_q is non-zero whenever RUN is entered, so the subtraction never
  // wraps and the counter never exceeds ref_len.
  assign w_last = (count_q == (ref_len_q - c_idx_one));

  always_comb begin
    state_d     = state_q;
    ref_len_d   = ref_len_q;
    thr_d       = thr_q;
    count_d     = count_q;
    res_score_d = res_score_q;
    res_pos_d   = res_pos_q;
    res_hit_d   = res_hit_q;
    w_trk_clr   = 1'b0;
    w_trk_upd   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ref_len_d = ref_len;
          thr_d     = threshold;
          count_d   = '0;
          w_trk_clr = 1'b1;
          if (ref_len == '0) begin
            // Empty run: report the saturated cost without enabling the array.
            state_d     = ST_DONE;
            res_score_d = c_cost_max;
            res_pos_d   = '0;
            res_hit_d   = (c_cost_max <= threshold);
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (dtw_valid) begin
          w_trk_upd = 1'b1;
          count_d   = count_q + c_idx_one;
          if (w_last) begin
            state_d     = ST_DONE;
            res_score_d = w_final_score;
            res_pos_d   = w_final_pos;
            res_hit_d   = (w_final_score <= thr_q);
          end
        end
      end

      ST_DONE: begin
        // A start arriving with the accept is dropped; IDLE must see it.
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ref_len_q   <= '0;
      thr_q       <= '0;
      count_q     <= '0;
      res_score_q <= c_cost_max;
      res_pos_q   <= '0;
      res_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_len_q   <= ref_len_d;
      thr_q       <= thr_d;
      count_q     <= count_d;
      res_score_q <= res_score_d;
      res_pos_q   <= res_pos_d;
      res_hit_q   <= res_hit_d;
    end
  end

  // Control outputs decode straight from the state register, so running
  // falls and res_valid rises on the same edge that enters DONE.
  assign running   = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign res_valid = (state_q == ST_DONE);
  assign res_score = res_score_q;
  assign res_pos   = res_pos_q;
  assign res_hit   = res_hit_q;

endmodule : dtw_result_collector
`default_nettype wire

// File: tb/tb_dtw_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtw_result_collector
// Description : Directed self-checking bench for dtw_result_collector.
//               Expected results are queued when a run is started and popped
//               when the collector presents its result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtw_result_collector;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned IDX_WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0]     score;
    logic [IDX_WIDTH-1:0] pos;
    logic                 hit;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [IDX_WIDTH-1:0] ref_len;
  logic [WIDTH-1:0]     threshold;
  logic [WIDTH-1:0]     dtw_in;
  logic                 dtw_valid;
  logic                 running;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ready;
  logic [WIDTH-1:0]     res_score;
  logic [IDX_WIDTH-1:0] res_pos;
  logic                 res_hit;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dtw_result_collector #(
    .WIDTH     (WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ref_len   (ref_len),
    .threshold (threshold),
    .dtw_in    (dtw_in),
    .dtw_valid (dtw_valid),
    .running   (running),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_score (res_score),
    .res_pos   (res_pos),
    .res_hit   (res_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks are entered and left at a falling edge.
  task automatic do_start(input logic [IDX_WIDTH-1:0] len, input logic [WIDTH-1:0] thr,
                          input logic [WIDTH-1:0] e_score, input logic [IDX_WIDTH-1:0] e_pos,
                          input logic e_hit);
    exp_t e;
    e.score = e_score;
    e.pos   = e_pos;
    e.hit   = e_hit;
    sb.push_back(e);
    start     = 1'b1;
    ref_len   = len;
    threshold = thr;
    @(negedge clk);
    start     = 1'b0;
    ref_len   = 32'hDEAD_BEEF;
    threshold = 16'h0000;
  endtask

  task automatic send(input logic [WIDTH-1:0] c);
    dtw_valid = 1'b1;
    dtw_in    = c;
    @(negedge clk);
    dtw_valid = 1'b0;
    dtw_in    = 16'h0000;
  endtask

  // Wait (bounded) for a result, compare it against the scoreboard head and
  // accept it. A start raised together with the accept must be ignored.
  task automatic collect(input string tag, input logic start_on_accept);
    exp_t e;
    int   n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_score"}, 32'(res_score), 32'(e.score));
      check({tag, "_pos"},   res_pos,        e.pos);
      check({tag, "_hit"},   32'(res_hit),   32'(e.hit));
    end
    res_ready = 1'b1;
    if (start_on_accept) begin
      start   = 1'b1;
      ref_len = 32'd5;
    end
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
    check({tag, "_idle"},       32'(busy),      32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] costs [5];
    logic             gap_pat [8];
    logic [WIDTH-1:0] held_score;
    logic [IDX_WIDTH-1:0] held_pos;
    int k;

    costs   = '{16'd40, 16'd12, 16'd7, 16'd9, 16'd7};
    gap_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; ref_len = '0; threshold = '0;
    dtw_in = '0; dtw_valid = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_running", 32'(running),   32'd0);
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_valid",   32'(res_valid), 32'd0);
    check("rst_score",   32'(res_score), 32'hFFFF);
    check("rst_pos",     res_pos,        32'd0);
    check("rst_hit",     32'(res_hit),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic run, tie at index 4 must not displace index 2.
    do_start(32'd5, 16'd10, 16'd7, 32'd2, 1'b1);
    check("t1_running_on", 32'(running), 32'd1);
    check("t1_busy",       32'(busy),    32'd1);
    for (int i = 0; i < 4; i++) send(costs[i]);
    check("t1_running_mid", 32'(running), 32'd1);
    send(costs[4]);
    check("t1_running_off", 32'(running),   32'd0);
    check("t1_valid_now",   32'(res_valid), 32'd1);
    collect("t1", 1'b0);

    // 2: same stream with gaps; invalid cycles carry cost 0 which must be ignored.
    do_start(32'd5, 16'd10, 16'd7, 32'd2, 1'b1);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      dtw_valid = gap_pat[i];
      dtw_in    = gap_pat[i] ? costs[k] : 16'h0000;
      if (gap_pat[i]) k++;
      @(negedge clk);
    end
    dtw_valid = 1'b0;
    collect("t2", 1'b0);

    // 3: backpressure, score equal to threshold is a hit; start in DONE ignored.
    do_start(32'd2, 16'd3, 16'd3, 32'd1, 1'b1);
    send(16'd5);
    send(16'd3);
    held_score = res_score;
    held_pos   = res_pos;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        start = 1'b1; ref_len = 32'd0; threshold = 16'hFFFF;
      end
      @(negedge clk);
      start = 1'b0;
      check("t3_hold_valid",   32'(res_valid), 32'd1);
      check("t3_hold_busy",    32'(busy),      32'd1);
      check("t3_hold_running", 32'(running),   32'd0);
      check("t3_hold_score",   32'(res_score), 32'(held_score));
      check("t3_hold_pos",     res_pos,        held_pos);
    end
    collect("t3", 1'b0);
    check("t3_idle_keep_score", 32'(res_score), 32'd3);
    check("t3_idle_keep_pos",   res_pos,        32'd1);

    // 5: reset after 2 of 8 samples discards the run.
    do_start(32'd8, 16'd100, 16'd0, 32'd0, 1'b0);
    send(16'd3);
    send(16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    check("t5_rst_running", 32'(running),   32'd0);
    check("t5_rst_valid",   32'(res_valid), 32'd0);
    check("t5_rst_busy",    32'(busy),      32'd0);
    check("t5_rst_score",   32'(res_score), 32'hFFFF);
    check("t5_rst_pos",     res_pos,        32'd0);
    do_start(32'd3, 16'd4, 16'd4, 32'd1, 1'b1);
    send(16'd5);
    send(16'd4);
    send(16'd6);
    collect("t5", 1'b0);

    // 4: empty run, threshold below all ones -> no hit; start on accept ignored.
    do_start(32'd0, 16'h1234, 16'hFFFF, 32'd0, 1'b0);
    check("t4a_running", 32'(running),   32'd0);
    check("t4a_valid",   32'(res_valid), 32'd1);
    collect("t4a", 1'b1);
    repeat (2) @(negedge clk);
    check("t4a_no_restart", 32'(busy), 32'd0);
    do_start(32'd0, 16'hFFFF, 16'hFFFF, 32'd0, 1'b1);
    check("t4b_running", 32'(running), 32'd0);
    collect("t4b", 1'b0);

    // 6: saturated costs never update min but still count.
    do_start(32'd4, 16'd100, 16'hFFFF, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) send(16'hFFFF);
    check("t6_running_3", 32'(running),   32'd1);
    check("t6_valid_3",   32'(res_valid), 32'd0);
    send(16'hFFFF);
    check("t6_valid_4",   32'(res_valid), 32'd1);
    collect("t6", 1'b0);

    // Single-sample run above threshold, minimum at index 0.
    do_start(32'd1, 16'd8, 16'd9, 32'd0, 1'b0);
    send(16'd9);
    collect("t7", 1'b0);

    // dtw_valid in IDLE must not start anything.
    send(16'd1);
    check("idle_valid_ignored", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dtw_result_collector
`default_nettype wire
